// File: rtl/axi_burst_splitter.sv
// rtl/axi_burst_splitter.sv - AXI4 write burst splitter: MAX_BURST-beat, 4 KiB-safe sub-bursts with merged B
module axi_burst_splitter #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int MAX_BURST      = 16,
  parameter int LEN_FIFO_DEPTH = 4
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [AXI_ID_WIDTH-1:0]   s_awid,
  input  logic [AXI_ADDR_WIDTH-1:0] s_awaddr,
  input  logic [7:0]                s_awlen,
  input  logic                      s_awvalid,
  output logic                      s_awready,
  input  logic [AXI_DATA_WIDTH-1:0] s_wdata,
  input  logic                      s_wlast,
  input  logic                      s_wvalid,
  output logic                      s_wready,
  output logic [AXI_ID_WIDTH-1:0]   s_bid,
  output logic [1:0]                s_bresp,
  output logic                      s_bvalid,
  input  logic                      s_bready,
  output logic [AXI_ID_WIDTH-1:0]   m_awid,
  output logic [AXI_ADDR_WIDTH-1:0] m_awaddr,
  output logic [3:0]                m_awlen,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [AXI_DATA_WIDTH-1:0] m_wdata,
  output logic                      m_wlast,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  output logic                      wlast_err
);

  localparam int BPB    = AXI_DATA_WIDTH / 8;
  localparam int BSHIFT = $clog2(BPB);
  localparam int PW     = (LEN_FIFO_DEPTH > 1) ? $clog2(LEN_FIFO_DEPTH) : 1;
  localparam logic [PW:0]   DEPTH    = (PW+1)'(LEN_FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_IDX = PW'(LEN_FIFO_DEPTH - 1);
  localparam logic [4:0]    MAXB     = 5'(MAX_BURST);
  localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~AXI_ADDR_WIDTH'((1 << BSHIFT) - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_B, RESP} state_t;

  state_t                    state;
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [8:0]                rem, tot, wtot, issued, bdone;
  logic [1:0]                bacc;

  logic [4:0]    len_mem [LEN_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [3:0]    beat;

  logic [12:0] room;
  logic [4:0]  rem_cap, room_cap, sub, head;
  logic        fifo_full, fifo_ne, s_aw_hs, aw_hs, w_hs, b_hs, push, pop;

  // Beats left before the next 4 KiB boundary; 4096 - 0 needs the 13th bit.
  assign room     = (13'd4096 - {1'b0, addr_q[11:0]}) >> BSHIFT;
  assign rem_cap  = (rem > {4'd0, MAXB}) ? MAXB : rem[4:0];
  assign room_cap = (room > {8'd0, MAXB}) ? MAXB : room[4:0];
  assign sub      = (rem_cap < room_cap) ? rem_cap : room_cap;

  assign fifo_full = (count == DEPTH);
  assign fifo_ne   = (count != '0);
  assign head      = len_mem[rd_ptr];

  assign m_awid    = id_q;
  assign m_awaddr  = addr_q;
  assign m_awlen   = 4'(sub - 5'd1);
  assign m_awvalid = (state == ISSUE) && !fifo_full;
  assign m_bready  = (state == ISSUE) || (state == WAIT_B);

  assign m_wdata  = s_wdata;
  assign m_wvalid = fifo_ne && s_wvalid;
  assign s_wready = fifo_ne && m_wready;
  assign m_wlast  = fifo_ne && ({1'b0, beat} == head - 5'd1);

  assign s_aw_hs = s_awvalid && s_awready;
  assign aw_hs   = m_awvalid && m_awready;
  assign w_hs    = m_wvalid && m_wready;
  assign b_hs    = m_bvalid && m_bready;
  assign push    = aw_hs;
  assign pop     = w_hs && m_wlast;

  // Severity order DECERR > SLVERR > OKAY; EXOKAY ranks as OKAY and is never stored.
  function automatic logic [1:0] merge_resp(input logic [1:0] acc, input logic [1:0] r);
    logic [1:0] sa, sr;
    sa = (acc == 2'b11) ? 2'd2 : ((acc == 2'b10) ? 2'd1 : 2'd0);
    sr = (r == 2'b11) ? 2'd2 : ((r == 2'b10) ? 2'd1 : 2'd0);
    return (sr > sa) ? r : acc;
  endfunction

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= IDLE;
      s_awready <= 1'b0;
      s_bvalid  <= 1'b0;
      s_bresp   <= 2'b00;
      s_bid     <= '0;
      id_q      <= '0;
      addr_q    <= '0;
      rem       <= '0;
      tot       <= '0;
      issued    <= '0;
      bdone     <= '0;
      bacc      <= 2'b00;
    end else begin
      if (b_hs) begin
        bdone <= bdone + 9'd1;
        bacc  <= merge_resp(bacc, m_bresp);
      end
      unique case (state)
        IDLE: begin
          s_awready <= 1'b1;
          if (s_aw_hs) begin
            id_q      <= s_awid;
            addr_q    <= s_awaddr & ALIGN_MASK;
            rem       <= {1'b0, s_awlen} + 9'd1;
            tot       <= {1'b0, s_awlen} + 9'd1;
            issued    <= '0;
            bdone     <= '0;
            bacc      <= 2'b00;
            s_awready <= 1'b0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (aw_hs) begin
            addr_q <= addr_q + (AXI_ADDR_WIDTH'(sub) << BSHIFT);
            rem    <= rem - {4'd0, sub};
            issued <= issued + 9'd1;
            if (rem == {4'd0, sub}) state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (bdone == issued) begin
            s_bvalid <= 1'b1;
            s_bid    <= id_q;
            s_bresp  <= bacc;
            state    <= RESP;
          end
        end
        RESP: begin
          if (s_bready) begin
            s_bvalid  <= 1'b0;
            s_awready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (push) len_mem[wr_ptr] <= sub;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      beat      <= '0;
      wtot      <= '0;
      wlast_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (w_hs) begin
        beat <= m_wlast ? 4'd0 : beat + 4'd1;
        wtot <= wtot + 9'd1;
        if (s_wlast != (wtot + 9'd1 == tot)) wlast_err <= 1'b1;
      end
      // Previous burst's W beats have all drained before a new AW is accepted.
      if (s_aw_hs) wtot <= '0;
    end
  end

endmodule

// File: tb/tb_axi_burst_splitter.sv
// tb/tb_axi_burst_splitter.sv - self-checking bench for axi_burst_splitter with a reference split model
module tb_axi_burst_splitter;
  localparam int FD = 4;

  logic        aclk = 1'b0;
  logic        areset;
  logic [3:0]  s_awid;
  logic [31:0] s_awaddr;
  logic [7:0]  s_awlen;
  logic        s_awvalid, s_awready;
  logic [63:0] s_wdata;
  logic        s_wlast, s_wvalid, s_wready;
  logic [3:0]  s_bid;
  logic [1:0]  s_bresp;
  logic        s_bvalid, s_bready;
  logic [3:0]  m_awid;
  logic [31:0] m_awaddr;
  logic [3:0]  m_awlen;
  logic        m_awvalid, m_awready;
  logic [63:0] m_wdata;
  logic        m_wlast, m_wvalid, m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid, m_bready;
  logic        wlast_err;

  always #5 aclk = ~aclk;

  axi_burst_splitter dut (
    .aclk(aclk), .areset(areset),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .wlast_err(wlast_err)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] aw_addr_q[$];
  logic [3:0]  aw_len_q[$];
  logic        w_last_q[$];
  logic [63:0] w_data_q[$];
  logic [63:0] sent_q[$];
  logic [1:0]  resp_q[$];
  logic [1:0]  b_pend[$];
  logic [1:0]  forced[$];
  int ahead = 0, max_ahead = 0, full_viol = 0, mb_cnt = 0, sb_cnt = 0;
  int aw_mode = 0, w_mode = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Downstream observer and memory-slave model
  always @(posedge aclk) begin
    if (areset) begin
      ahead = 0;
      b_pend.delete();
    end else begin
      if (ahead >= FD && m_awvalid) full_viol++;
      if (m_bvalid && m_bready) begin
        void'(b_pend.pop_front());
        mb_cnt++;
      end
      if (m_awvalid && m_awready) begin
        aw_addr_q.push_back(m_awaddr);
        aw_len_q.push_back(m_awlen);
        ahead++;
      end
      if (m_wvalid && m_wready) begin
        w_last_q.push_back(m_wlast);
        w_data_q.push_back(m_wdata);
        if (m_wlast) begin
          ahead--;
          b_pend.push_back((resp_q.size() != 0) ? resp_q.pop_front() : 2'b00);
        end
      end
      if (s_bvalid && s_bready) sb_cnt++;
      if (ahead > max_ahead) max_ahead = ahead;
    end
  end

  always @(negedge aclk) begin
    m_awready = (aw_mode == 0) ? 1'b1 : 1'($urandom % 2);
    m_wready  = (w_mode == 0) ? 1'b1 : ((w_mode == 1) ? ~m_wready : 1'($urandom % 2));
    m_bvalid  = (b_pend.size() != 0);
    m_bresp   = m_bvalid ? b_pend[0] : 2'b00;
  end

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    int n = 0;
    @(negedge aclk);
    s_awid = id; s_awaddr = addr; s_awlen = len; s_awvalid = 1'b1;
    #1;
    while (!s_awready && n < 2000) begin @(negedge aclk); #1; n++; end
    chk("aw_accept", n < 2000, 1);
    @(posedge aclk); #1;
    s_awvalid = 1'b0;
  endtask

  task automatic send_beats(input int n, input int len, input int bad);
    for (int b = 0; b < n; b++) begin
      int t = 0;
      logic [63:0] d;
      d = {$urandom, $urandom};
      @(negedge aclk);
      s_wdata = d;
      s_wlast = (bad >= 0) ? (b == bad) : (b == len);
      s_wvalid = 1'b1;
      #1;
      while (!s_wready && t < 2000) begin @(negedge aclk); #1; t++; end
      chk("w_accept", t < 2000, 1);
      @(posedge aclk); #1;
      sent_q.push_back(d);
    end
    s_wvalid = 1'b0;
  endtask

  task automatic clear_logs();
    aw_addr_q.delete(); aw_len_q.delete();
    w_last_q.delete(); w_data_q.delete(); sent_q.delete(); resp_q.delete();
  endtask

  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int bad, input int bdelay, input logic exp_err);
    logic [31:0] ea[$];
    int el[$];
    int ends[$];
    logic [31:0] a;
    int r, s, room, cum, sev, sev_max, n, sb0;
    logic [1:0] rs, exp_resp;
    logic exp_last;
    clear_logs();
    mb_cnt = 0;
    sb0 = sb_cnt;
    a = addr & ~32'h7;
    r = len + 1;
    cum = 0;
    sev_max = 0;
    while (r > 0) begin
      room = (4096 - int'(a[11:0])) / 8;
      s = r;
      if (s > 16) s = 16;
      if (s > room) s = room;
      ea.push_back(a);
      el.push_back(s - 1);
      cum += s;
      ends.push_back(cum);
      a += 32'(s * 8);
      r -= s;
      rs = (forced.size() != 0) ? forced.pop_front() : 2'($urandom % 4);
      resp_q.push_back(rs);
      sev = (rs == 2'b11) ? 2 : ((rs == 2'b10) ? 1 : 0);
      if (sev > sev_max) sev_max = sev;
    end
    exp_resp = (sev_max == 2) ? 2'b11 : ((sev_max == 1) ? 2'b10 : 2'b00);

    send_aw(id, addr, 8'(len));
    send_beats(len + 1, len, bad);

    n = 0;
    @(negedge aclk); #1;
    while (!s_bvalid && n < 3000) begin @(negedge aclk); #1; n++; end
    chk("bvalid_seen", s_bvalid, 1);
    chk("mb_done_before_sb", mb_cnt, ea.size());
    chk("bid", s_bid, id);
    chk("bresp", s_bresp, exp_resp);
    for (int k = 0; k < bdelay; k++) begin
      @(negedge aclk); #1;
      chk("bvalid_hold", s_bvalid, 1);
      chk("bid_hold", s_bid, id);
      chk("bresp_hold", s_bresp, exp_resp);
    end
    s_bready = 1'b1;
    @(posedge aclk); #1;
    s_bready = 1'b0;
    @(negedge aclk); #1;
    chk("bvalid_clear", s_bvalid, 0);
    chk("sb_once", sb_cnt - sb0, 1);

    chk("aw_count", aw_addr_q.size(), ea.size());
    for (int i = 0; i < ea.size() && i < aw_addr_q.size(); i++) begin
      chk("aw_addr", aw_addr_q[i], ea[i]);
      chk("aw_len", aw_len_q[i], el[i]);
    end
    chk("w_count", w_last_q.size(), len + 1);
    for (int k = 0; k < w_last_q.size() && k < sent_q.size(); k++) begin
      exp_last = 1'b0;
      foreach (ends[j]) if (ends[j] == k + 1) exp_last = 1'b1;
      chk("w_last", w_last_q[k], exp_last);
      chk("w_data", w_data_q[k], sent_q[k]);
    end
    chk("wlast_err", wlast_err, exp_err);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_awready"}, s_awready, 0);
    chk({tag, "_m_awvalid"}, m_awvalid, 0);
    chk({tag, "_s_bvalid"}, s_bvalid, 0);
    chk({tag, "_wlast_err"}, wlast_err, 0);
    chk({tag, "_s_bresp"}, s_bresp, 0);
    chk({tag, "_m_bready"}, m_bready, 0);
    chk({tag, "_s_wready"}, s_wready, 0);
    chk({tag, "_m_wvalid"}, m_wvalid, 0);
  endtask

  initial begin
    areset = 1'b1;
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awvalid = 1'b0;
    s_wdata = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0; m_bresp = 2'b00;
    repeat (3) @(negedge aclk);
    #1;
    check_reset_outputs("reset");
    @(negedge aclk);
    areset = 1'b0;
    #4;
    chk("awready_before_first_edge", s_awready, 0);
    @(posedge aclk); #1;
    chk("awready_after_release", s_awready, 1);

    forced = '{2'b00};
    run_burst(4'h5, 32'h0000_0000, 0, -1, 0, 1'b0);
    forced = '{2'b00, 2'b00, 2'b00};
    run_burst(4'h3, 32'h0000_0100, 39, -1, 0, 1'b0);
    forced = '{2'b00, 2'b00};
    run_burst(4'hA, 32'h0000_0FE8, 7, -1, 1, 1'b0);

    w_mode = 1; max_ahead = 0; full_viol = 0;
    forced.delete();
    for (int i = 0; i < 16; i++) forced.push_back(2'b00);
    run_burst(4'h7, 32'h0000_2000, 255, -1, 0, 1'b0);
    chk("max_ahead", max_ahead, FD);
    chk("awvalid_while_full", full_viol, 0);
    w_mode = 0;

    forced = '{2'b00, 2'b10, 2'b00};
    run_burst(4'h1, 32'h0000_0000, 47, -1, 5, 1'b0);
    forced = '{2'b00, 2'b11};
    run_burst(4'h2, 32'h0001_0000, 31, -1, 2, 1'b0);
    forced = '{2'b01, 2'b00};
    run_burst(4'hE, 32'h0002_0000, 31, -1, 0, 1'b0);

    forced = '{2'b00};
    run_burst(4'hC, 32'h0000_0040, 3, 2, 0, 1'b1);

    clear_logs();
    send_aw(4'h9, 32'h0000_3000, 8'd63);
    send_beats(10, 63, -1);
    @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk); #1;
    check_reset_outputs("midreset");
    resp_q.delete();
    @(negedge aclk);
    areset = 1'b0;
    #4;
    chk("mid_awready_before_edge", s_awready, 0);
    @(posedge aclk); #1;
    chk("mid_awready_after_release", s_awready, 1);

    aw_mode = 2; w_mode = 2;
    forced.delete();
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra;
      int rl;
      ra = $urandom;
      rl = (i % 2 == 0) ? int'($urandom % 256) : int'($urandom % 24);
      run_burst(4'($urandom), ra, rl, -1, int'($urandom % 4), 1'b0);
    end
    aw_mode = 0; w_mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_burst_splitter.md
Name: axi_burst_splitter

Overview:
- Write-path AXI4 adapter placed directly upstream of the DDR memory slave.
- Accepts full AXI4 write bursts of 1-256 beats and reissues them downstream as INCR sub-bursts of at most MAX_BURST beats that never cross a 4 KiB boundary.
- Regenerates wlast on each downstream sub-burst and merges the downstream B responses into one response per original burst.
- One original write burst is in flight at a time.

Parameters:
- AXI_ADDR_WIDTH, 32: address width.
- AXI_DATA_WIDTH, 64: data width. Bytes per beat BPB = AXI_DATA_WIDTH/8; BSHIFT = log2(BPB).
- AXI_ID_WIDTH, 4: ID width.
- MAX_BURST, 16: maximum downstream beats per sub-burst. Must be a power of 2, at most 16.
- LEN_FIFO_DEPTH, 4: depth of the FIFO of issued sub-burst lengths that drives W-path wlast generation.

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous, active-high reset
- s_awid  in  AXI_ID_WIDTH  upstream write ID
- s_awaddr  in  AXI_ADDR_WIDTH  upstream start address
- s_awlen  in  8  upstream beats minus 1
- s_awvalid / s_awready  in / out  1  upstream AW handshake
- s_wdata  in  AXI_DATA_WIDTH  upstream write data
- s_wlast  in  1  upstream last beat (checked only, never forwarded)
- s_wvalid / s_wready  in / out  1  upstream W handshake
- s_bid  out  AXI_ID_WIDTH  merged response ID
- s_bresp  out  2  merged response
- s_bvalid / s_bready  out / in  1  upstream B handshake
- m_awid  out  AXI_ID_WIDTH  downstream ID (the latched s_awid)
- m_awaddr  out  AXI_ADDR_WIDTH  sub-burst address
- m_awlen  out  4  sub-burst beats minus 1
- m_awvalid / m_awready  out / in  1  downstream AW handshake
- m_wdata  out  AXI_DATA_WIDTH  pass-through data
- m_wlast  out  1  regenerated last beat of sub-burst
- m_wvalid / m_wready  out / in  1  downstream W handshake
- m_bresp  in  2  downstream response
- m_bvalid / m_bready  in / out  1  downstream B handshake (m_bid is not used)
- wlast_err  out  1  sticky flag: upstream wlast mismatch

Behaviour:
- Reset (areset high at a clock edge):
  - State goes to IDLE. All counters, the length FIFO and accumulators clear.
  - s_awready, m_awvalid, s_bvalid and wlast_err are 0.
  - s_bresp = 00 and m_bready = 0.
  - Reset mid-burst abandons the burst silently; no B response is produced.
- State machine:
  - IDLE: s_awready = 1 (registered; first 1 is the cycle after reset deasserts).
    - On s_aw handshake, latch: id; addr with low BSHIFT bits forced to 0; rem = s_awlen+1 (9 bits); tot = s_awlen+1.
    - Clear issued, bdone, bacc. Go to ISSUE.
  - ISSUE: sub = min(rem, MAX_BURST, (4096 - addr[11:0]) >> BSHIFT), computed combinationally from the registers.
    - Drive m_awaddr = addr and m_awlen = sub-1.
    - m_awvalid = 1 while the length FIFO is not full. Once asserted, m_awvalid and the payload stay stable until m_awready.
    - On handshake: push sub to the FIFO; addr += sub<<BSHIFT; rem -= sub; issued += 1. If rem becomes 0, go to WAIT_B.
  - WAIT_B: collect the remaining B responses.
    - When bdone == issued with rem == 0, set s_bvalid = 1, s_bid = id, s_bresp = bacc. Go to RESP.
  - RESP: hold s_bvalid and payload until s_bready. On handshake go to IDLE.
- W path (independent of state, except cleared by reset):
  - If the FIFO is non-empty: m_wvalid = s_wvalid, s_wready = m_wready, m_wdata = s_wdata, m_wlast = (beat == head-1).
  - If the FIFO is empty: s_wready = 0 and m_wvalid = 0. W data therefore never precedes its AW issue.
  - On a W handshake: beat += 1 and wtot += 1. On the beat where m_wlast = 1, pop the FIFO and clear beat.
  - wlast_err sets when a handshake has s_wlast != (wtot+1 == tot). It clears only on reset.
- B path:
  - m_bready = 1 in ISSUE and WAIT_B.
  - On a handshake: bdone += 1; bacc = max(bacc, m_bresp). DECERR > SLVERR > OKAY; EXOKAY counts as OKAY.
  - B responses may arrive while ISSUE is still issuing; the completion check waits for rem == 0.
- Simultaneous events:
  - FIFO push and pop in the same cycle leave the count unchanged.
  - An m_b handshake on the same cycle as the final AW handshake is counted.
- Widths and limits:
  - rem, tot, wtot: 9 bits. issued, bdone: 9 bits.
  - The 4 KiB computation uses 13-bit arithmetic; 4096 - 0 is valid.
  - Throughput: 1 AW per cycle when m_awready is held high. W is zero-latency combinational pass-through.

Test Plan:
- addr 0x0000_0000, awlen=0, 1 W beat with wlast=1, m_bresp OKAY → one m_aw (addr 0x0, len 0), m_wlast on beat 1, s_bresp 00 with bid echoed, wlast_err=0.
- addr 0x0000_0100, awlen=39 (40 beats, 64-bit) → m_aw sequence 0x100/15, 0x180/15, 0x200/7; m_wlast on beats 16, 32, 40; exactly one s_bvalid after the third m_b.
- addr 0x0000_0FE8, awlen=7 → m_aw sequence 0xFE8/2, 0x1000/4 (4 KiB split); m_wlast on beats 3 and 8.
- awlen=255 aligned; m_awready held high and m_wready toggled 1/0 → 16 sub-bursts of len 15; at most LEN_FIFO_DEPTH AWs ahead of the W path; m_awvalid drops while the FIFO is full.
- Sub-burst responses OKAY, SLVERR, OKAY → s_bresp=10. Responses OKAY, DECERR → s_bresp=11. s_bready held low 5 cycles → s_bvalid and payload stable throughout.
- Upstream sends s_wlast=1 on beat 3 of a 4-beat burst → wlast_err=1, data still forwarded; areset mid-burst → all outputs at reset values next cycle, s_awready=1 the cycle after release.
